// File: rtl/pic_qphase_pkg.sv
// Shared types for the PIC16F84 phase sequencer: FSM states, instruction phases
// and the one-hot strobe encoding used to drive q1..q4.
package pic_qphase_pkg;

    localparam int TCY_W = 8;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_PWRT  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PH_Q1 = 2'd0,
        PH_Q2 = 2'd1,
        PH_Q3 = 2'd2,
        PH_Q4 = 2'd3
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(2'(p + 2'd1));
    endfunction

    // Bit 0 is q1, bit 3 is q4.
    function automatic logic [3:0] phase_onehot(input phase_t p);
        return 4'b0001 << p;
    endfunction

endpackage

// File: rtl/pic_port_wrbuf.sv
// One-entry port-latch write buffer; a pending value reaches the pin latch only
// at the end of a Q1 cycle so drive levels never change mid-instruction.
module pic_port_wrbuf #(
    parameter int PORT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_clr,
    input  logic              i_run,
    input  logic              i_q1,
    input  logic              i_wr_valid,
    input  logic [PORT_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic [PORT_W-1:0] o_port_lat
);

    logic              r_pend_v;
    logic [PORT_W-1:0] r_pend_d;
    logic [PORT_W-1:0] r_port_lat;
    logic              w_accept;
    logic              w_apply;

    // Handshake: a write transfers on any edge where i_wr_valid and o_wr_ready
    // are both high; o_wr_ready depends on registered state only, and a
    // requester must hold valid and data stable until that edge.
    assign o_wr_ready = i_run && (!r_pend_v || i_q1);
    assign w_accept   = i_wr_valid && o_wr_ready;
    assign w_apply    = i_q1 && r_pend_v;
    assign o_port_lat = r_port_lat;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_pend_v   <= 1'b0;
            r_pend_d   <= '0;
            r_port_lat <= '0;
        end else begin
            if (w_apply) begin
                r_port_lat <= r_pend_d;
            end
            if (w_accept) begin
                r_pend_d <= i_wr_data;
                r_pend_v <= 1'b1;
            end else if (w_apply) begin
                r_pend_v <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pic_qphase_ctrl.sv
// Instruction-phase sequencer: holds the core in reset under MCLR and the
// power-up timer, then rotates Q1..Q4 and counts completed instruction cycles.
module pic_qphase_ctrl
    import pic_qphase_pkg::*;
#(
    parameter int PWRT_CYCLES = 16,
    parameter int PORT_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mclr,
    input  logic              i_wr_valid,
    input  logic [PORT_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic              o_q1,
    output logic              o_q2,
    output logic              o_q3,
    output logic              o_q4,
    output logic              o_por_busy,
    output logic [PORT_W-1:0] o_port_lat,
    output logic [TCY_W-1:0]  o_tcy_cnt,
    output state_t            o_state
);

    localparam logic [15:0] PWRT_LAST = 16'(PWRT_CYCLES - 1);

    state_t            r_state;
    phase_t            r_phase;
    logic [3:0]        r_q;
    logic              r_por_busy;
    logic [15:0]       r_pwrt_cnt;
    logic [TCY_W-1:0]  r_tcy_cnt;
    logic              w_clr;
    logic              w_run;

    // Either source of reset takes effect on the very next edge.
    assign w_clr = i_rst || !i_mclr;
    assign w_run = (r_state == ST_RUN);

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_state    <= ST_RESET;
            r_phase    <= PH_Q1;
            r_q        <= 4'b0000;
            r_por_busy <= 1'b1;
            r_pwrt_cnt <= '0;
            r_tcy_cnt  <= '0;
        end else begin
            case (r_state)
                ST_PWRT: begin
                    if (r_pwrt_cnt == PWRT_LAST) begin
                        r_state    <= ST_RUN;
                        r_phase    <= PH_Q1;
                        r_q        <= phase_onehot(PH_Q1);
                        r_por_busy <= 1'b0;
                    end else begin
                        r_pwrt_cnt <= r_pwrt_cnt + 16'd1;
                    end
                end
                ST_RUN: begin
                    r_phase <= next_phase(r_phase);
                    r_q     <= phase_onehot(next_phase(r_phase));
                    if (r_phase == PH_Q4) begin
                        r_tcy_cnt <= r_tcy_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_PWRT;
                    r_pwrt_cnt <= '0;
                    r_por_busy <= 1'b1;
                    r_q        <= 4'b0000;
                end
            endcase
        end
    end

    pic_port_wrbuf #(
        .PORT_W(PORT_W)
    ) u_wrbuf (
        .i_clk      (i_clk),
        .i_clr      (w_clr),
        .i_run      (w_run),
        .i_q1       (r_q[0]),
        .i_wr_valid (i_wr_valid),
        .i_wr_data  (i_wr_data),
        .o_wr_ready (o_wr_ready),
        .o_port_lat (o_port_lat)
    );

    assign o_q1       = r_q[0];
    assign o_q2       = r_q[1];
    assign o_q3       = r_q[2];
    assign o_q4       = r_q[3];
    assign o_por_busy = r_por_busy;
    assign o_tcy_cnt  = r_tcy_cnt;
    assign o_state    = r_state;

endmodule

// File: tb/tb_pic_qphase_ctrl.sv
// Directed bench for pic_qphase_ctrl: power-up, write-buffer timing, MCLR,
// tcy_cnt wrap, PWRT restart on an MCLR glitch and reset priority.
module tb_pic_qphase_ctrl;
  import pic_qphase_pkg::*;

  localparam int PORT_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mclr = 1'b1;
  logic              wr_valid = 1'b0;
  logic [PORT_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic              q1, q2, q3, q4;
  logic              por_busy;
  logic [PORT_W-1:0] port_lat;
  logic [7:0]        tcy_cnt;
  state_t            state;

  int checks = 0;
  int errors = 0;

  pic_qphase_ctrl #(.PWRT_CYCLES(16), .PORT_W(PORT_W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_mclr     (mclr),
    .i_wr_valid (wr_valid),
    .i_wr_data  (wr_data),
    .o_wr_ready (wr_ready),
    .o_q1       (q1),
    .o_q2       (q2),
    .o_q3       (q3),
    .o_q4       (q4),
    .o_por_busy (por_busy),
    .o_port_lat (port_lat),
    .o_tcy_cnt  (tcy_cnt),
    .o_state    (state)
  );

  // clock / timeout
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       mclr;
    logic       v;
    logic [7:0] d;
    logic [3:0] q;     // {q4,q3,q2,q1}
    logic       busy;
    logic       rdy;
    logic [7:0] lat;
    logic [7:0] tcy;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t vec(input logic m, input logic v, input logic [7:0] d,
                               input logic [3:0] q, input logic busy, input logic rdy,
                               input logic [7:0] lat, input logic [7:0] tcy);
    vec_t r;
    r.mclr = m; r.v = v; r.d = d; r.q = q;
    r.busy = busy; r.rdy = rdy; r.lat = lat; r.tcy = tcy;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic m, input logic v, input logic [7:0] d);
    rst = r; mclr = m; wr_valid = v; wr_data = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] qs();
    return {q4, q3, q2, q1};
  endfunction

  initial begin
    // Vectors start in the first Q1 after power-up: tcy=0, port_lat=0, buffer empty.
    tbl[0]  = vec(1, 0, 8'h00, 4'b0010, 0, 1, 8'h00, 0);
    tbl[1]  = vec(1, 1, 8'hA5, 4'b0100, 0, 0, 8'h00, 0);  // write in Q2
    tbl[2]  = vec(1, 0, 8'h00, 4'b1000, 0, 0, 8'h00, 0);
    tbl[3]  = vec(1, 0, 8'h00, 4'b0001, 0, 1, 8'h00, 1);
    tbl[4]  = vec(1, 0, 8'h00, 4'b0010, 0, 1, 8'hA5, 1);  // applied end of Q1
    tbl[5]  = vec(1, 1, 8'h3C, 4'b0100, 0, 0, 8'hA5, 1);
    tbl[6]  = vec(1, 0, 8'h00, 4'b1000, 0, 0, 8'hA5, 1);
    tbl[7]  = vec(1, 0, 8'h00, 4'b0001, 0, 1, 8'hA5, 2);
    tbl[8]  = vec(1, 1, 8'hC3, 4'b0010, 0, 0, 8'h3C, 2);  // apply 3C + accept C3
    tbl[9]  = vec(1, 1, 8'h99, 4'b0100, 0, 0, 8'h3C, 2);  // ignored, not ready
    tbl[10] = vec(1, 1, 8'h99, 4'b1000, 0, 0, 8'h3C, 2);  // ignored, not ready
    tbl[11] = vec(1, 0, 8'h00, 4'b0001, 0, 1, 8'h3C, 3);
    tbl[12] = vec(1, 0, 8'h00, 4'b0010, 0, 1, 8'hC3, 3);
    tbl[13] = vec(1, 0, 8'h00, 4'b0100, 0, 1, 8'hC3, 3);
    tbl[14] = vec(1, 0, 8'h00, 4'b1000, 0, 1, 8'hC3, 3);
    tbl[15] = vec(1, 0, 8'h00, 4'b0001, 0, 1, 8'hC3, 4);
    tbl[16] = vec(1, 1, 8'h0F, 4'b0010, 0, 0, 8'hC3, 4);  // accept in Q1, empty
    tbl[17] = vec(1, 0, 8'h00, 4'b0100, 0, 0, 8'hC3, 4);
    tbl[18] = vec(1, 0, 8'h00, 4'b1000, 0, 0, 8'hC3, 4);
    tbl[19] = vec(1, 0, 8'h00, 4'b0001, 0, 1, 8'hC3, 5);
    tbl[20] = vec(1, 0, 8'h00, 4'b0010, 0, 1, 8'h0F, 5);  // 4 cycles later
    tbl[21] = vec(1, 1, 8'hFF, 4'b0100, 0, 0, 8'h0F, 5);
    tbl[22] = vec(1, 0, 8'h00, 4'b1000, 0, 0, 8'h0F, 5);
    tbl[23] = vec(1, 0, 8'h00, 4'b0001, 0, 1, 8'h0F, 6);
    tbl[24] = vec(1, 1, 8'h55, 4'b0010, 0, 0, 8'hFF, 6);
    tbl[25] = vec(1, 0, 8'h00, 4'b0100, 0, 0, 8'hFF, 6);  // Q3, 55 pending
    tbl[26] = vec(0, 0, 8'h00, 4'b0000, 1, 0, 8'h00, 0);  // mclr low
    tbl[27] = vec(1, 0, 8'h00, 4'b0000, 1, 0, 8'h00, 0);  // RESET -> PWRT

    // reset
    step(1, 1, 0, 8'h00);
    step(1, 1, 1, 8'h77);
    check("rst_q", {28'd0, qs()}, 32'h0);
    check("rst_busy", {31'd0, por_busy}, 32'h1);
    check("rst_ready", {31'd0, wr_ready}, 32'h0);
    check("rst_lat", {24'd0, port_lat}, 32'h00);
    check("rst_tcy", {24'd0, tcy_cnt}, 32'h00);
    check("rst_state", {30'd0, state}, {30'd0, ST_RESET});

    // power-up: 16 busy edges after release, q1 on the 17th
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, 8'h00);
      check($sformatf("pwr_busy_%0d", i), {31'd0, por_busy}, 32'h1);
      check($sformatf("pwr_q_%0d", i), {28'd0, qs()}, 32'h0);
    end
    step(0, 1, 0, 8'h00);
    check("pwr_q1", {28'd0, qs()}, 32'h1);
    check("pwr_busy_off", {31'd0, por_busy}, 32'h0);

    // table-driven run-phase vectors
    for (int i = 0; i < 28; i++) begin
      step(0, tbl[i].mclr, tbl[i].v, tbl[i].d);
      check($sformatf("v%0d_q", i), {28'd0, qs()}, {28'd0, tbl[i].q});
      check($sformatf("v%0d_busy", i), {31'd0, por_busy}, {31'd0, tbl[i].busy});
      check($sformatf("v%0d_ready", i), {31'd0, wr_ready}, {31'd0, tbl[i].rdy});
      check($sformatf("v%0d_lat", i), {24'd0, port_lat}, {24'd0, tbl[i].lat});
      check($sformatf("v%0d_tcy", i), {24'd0, tcy_cnt}, {24'd0, tbl[i].tcy});
    end

    // after mclr release: 15 more PWRT edges, then q1; 0x55 never shows
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 0, 8'h00);
      check($sformatf("mclr_q_%0d", i), {28'd0, qs()}, 32'h0);
      check($sformatf("mclr_lat_%0d", i), {24'd0, port_lat}, 32'h00);
    end
    step(0, 1, 0, 8'h00);
    check("mclr_q1", {28'd0, qs()}, 32'h1);

    // tcy_cnt wrap: 256 instruction cycles
    for (int i = 0; i < 1020; i++) step(0, 1, 0, 8'h00);
    check("wrap_255", {24'd0, tcy_cnt}, 32'hFF);
    check("wrap_255_q", {28'd0, qs()}, 32'h1);
    check("wrap_lat", {24'd0, port_lat}, 32'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
    check("wrap_q4", {28'd0, qs()}, 32'h8);
    check("wrap_pre", {24'd0, tcy_cnt}, 32'hFF);
    step(0, 1, 0, 8'h00);
    check("wrap_0", {24'd0, tcy_cnt}, 32'h00);

    // mclr glitch at PWRT count 10 restarts the timer
    step(0, 0, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    check("gl_state_pwrt", {30'd0, state}, {30'd0, ST_PWRT});
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    check("gl_state_reset", {30'd0, state}, {30'd0, ST_RESET});
    check("gl_busy", {31'd0, por_busy}, 32'h1);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0, 8'h00);
      check($sformatf("gl_q_%0d", i), {28'd0, qs()}, 32'h0);
    end
    step(0, 1, 0, 8'h00);
    check("gl_q1", {28'd0, qs()}, 32'h1);

    // reset priority with rst and mclr asserted together in RUN
    step(0, 1, 1, 8'h12);
    step(0, 1, 0, 8'h00);
    step(1, 0, 1, 8'h34);
    check("rp_q", {28'd0, qs()}, 32'h0);
    check("rp_busy", {31'd0, por_busy}, 32'h1);
    check("rp_ready", {31'd0, wr_ready}, 32'h0);
    check("rp_lat", {24'd0, port_lat}, 32'h00);
    check("rp_tcy", {24'd0, tcy_cnt}, 32'h00);
    check("rp_state", {30'd0, state}, {30'd0, ST_RESET});
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 8'h00);
      check($sformatf("rp_hold_%0d", i), {30'd0, state}, {30'd0, ST_RESET});
      check($sformatf("rp_hold_busy_%0d", i), {31'd0, por_busy}, 32'h1);
    end
    step(0, 1, 0, 8'h00);
    check("rp_release", {30'd0, state}, {30'd0, ST_PWRT});

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
